// File: rtl/cfg_loader_pkg.sv
// Shared types and helpers for the config-chain frame loader.
// The CHECK state is only present when CFG_FRAME_LOADER_PARITY_EN is defined.
package cfg_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ID,
        ST_LOAD
`ifdef CFG_FRAME_LOADER_PARITY_EN
        , ST_CHECK
`endif
    } state_t;

    // Number of beats needed to carry a field of `width` bits over `lanes` lanes.
    function automatic int beats(input int width, input int lanes);
        return (width + lanes - 1) / lanes;
    endfunction

    // Reserved broadcast frame ID: all ones of the ID field.
    function automatic int bcast_id(input int id_width);
        return int'((33'd1 << id_width) - 33'd1);
    endfunction

endpackage

// File: rtl/cfg_shadow_sr.sv
// Multi-lane LSB-first shift register with clear and write enable.
// data_nxt is the value the register takes at the next edge, so callers can commit the final beat without a bubble.
module cfg_shadow_sr
    import cfg_loader_pkg::*;
#(
    parameter int WIDTH = 132,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [LANES-1:0] din,
    output logic [WIDTH-1:0] data_nxt
);

    localparam int SR_W = beats(WIDTH, LANES) * LANES;

    logic [SR_W-1:0] sr_q;
    logic [SR_W-1:0] sr_shift;
    logic [SR_W-1:0] sr_d;

    // New beats enter at the top, so after a full field the first beat sits in the low lanes.
    generate
        if (SR_W == LANES) begin : g_single
            assign sr_shift = din;
        end else begin : g_multi
            assign sr_shift = {din, sr_q[SR_W-1:LANES]};
        end
    endgenerate

    always_comb begin
        sr_d = sr_q;
        if (clr) begin
            sr_d = '0;
        end else if (we) begin
            sr_d = sr_shift;
        end
    end

    // NOTE: this wide register is still reset: a cleared shadow is part of the defined reset state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    // Pad bits above WIDTH are carried along but never exposed.
    assign data_nxt = sr_d[WIDTH-1:0];

endmodule

// File: rtl/cfg_frame_loader.sv
// Config-chain frame loader: forwards the chain with one cycle of latency and commits addressed
// or broadcast payloads to cfg. Define CFG_FRAME_LOADER_PARITY_EN for the parity CHECK beat and cfg_err.
module cfg_frame_loader
    import cfg_loader_pkg::*;
#(
    parameter int ID_WIDTH = 3,
    parameter int ID       = 7,
    parameter int CFG_SIZE = 132,
    parameter int CHAIN_W  = 1,
    parameter bit BCAST    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_in_start,
    input  logic [CHAIN_W-1:0]  cfg_bits_in,
    output logic                cfg_out_start,
    output logic [CHAIN_W-1:0]  cfg_bits_out,
    output logic [CFG_SIZE-1:0] cfg,
    output logic                cfg_done,
`ifdef CFG_FRAME_LOADER_PARITY_EN
    output logic                cfg_err,
`endif
    output logic                busy
);

    localparam int ID_BEATS  = beats(ID_WIDTH, CHAIN_W);
    localparam int PL_BEATS  = beats(CFG_SIZE, CHAIN_W);
    localparam int MAX_BEATS = (ID_BEATS > PL_BEATS) ? ID_BEATS : PL_BEATS;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);

    localparam logic [CNT_W-1:0]    ID_LAST  = CNT_W'(ID_BEATS - 1);
    localparam logic [CNT_W-1:0]    PL_LAST  = CNT_W'(PL_BEATS - 1);
    localparam logic [ID_WIDTH-1:0] ID_VAL   = ID_WIDTH'(ID);
    localparam logic [ID_WIDTH-1:0] BCAST_ID = ID_WIDTH'(bcast_id(ID_WIDTH));

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q, match_d;
    logic               id_we, sh_we, clr, commit;
    logic [ID_WIDTH-1:0] id_nxt;
    logic [CFG_SIZE-1:0] shadow_nxt;
    logic               id_hit;
`ifdef CFG_FRAME_LOADER_PARITY_EN
    logic               err_d;
    logic               parity_ok;
`endif

    // Forward pipe: unconditional, so downstream tiles see every frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_out_start <= 1'b0;
            cfg_bits_out  <= '0;
        end else begin
            cfg_out_start <= cfg_in_start;
            cfg_bits_out  <= cfg_bits_in;
        end
    end

    cfg_shadow_sr #(
        .WIDTH (ID_WIDTH),
        .LANES (CHAIN_W)
    ) u_id_sr (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .we       (id_we),
        .din      (cfg_bits_in),
        .data_nxt (id_nxt)
    );

    cfg_shadow_sr #(
        .WIDTH (CFG_SIZE),
        .LANES (CHAIN_W)
    ) u_shadow_sr (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .we       (sh_we),
        .din      (cfg_bits_in),
        .data_nxt (shadow_nxt)
    );

    assign id_hit = (id_nxt == ID_VAL) || (BCAST && (id_nxt == BCAST_ID));

`ifdef CFG_FRAME_LOADER_PARITY_EN
    // Even parity: payload bits plus the lane-0 check bit XOR to zero.
    assign parity_ok = ~((^shadow_nxt) ^ cfg_bits_in[0]);
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        match_d = match_q;
        id_we   = 1'b0;
        sh_we   = 1'b0;
        clr     = 1'b0;
        commit  = 1'b0;
`ifdef CFG_FRAME_LOADER_PARITY_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cfg_in_start) begin
                    state_d = ST_ID;
                    cnt_d   = '0;
                end
            end
            ST_ID: begin
                id_we = 1'b1;
                if (cnt_q == ID_LAST) begin
                    match_d = id_hit;
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                sh_we = match_q;
                if (cnt_q == PL_LAST) begin
                    cnt_d = '0;
`ifdef CFG_FRAME_LOADER_PARITY_EN
                    state_d = ST_CHECK;
`else
                    commit  = match_q;
                    state_d = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef CFG_FRAME_LOADER_PARITY_EN
            ST_CHECK: begin
                state_d = ST_IDLE;
                commit  = match_q && parity_ok;
                err_d   = match_q && !parity_ok;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // A start strobe mid-frame drops everything captured so far and restarts the ID phase.
        if (cfg_in_start && (state_q != ST_IDLE)) begin
            state_d = ST_ID;
            cnt_d   = '0;
            match_d = 1'b0;
            id_we   = 1'b0;
            sh_we   = 1'b0;
            clr     = 1'b1;
            commit  = 1'b0;
`ifdef CFG_FRAME_LOADER_PARITY_EN
            err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            match_q  <= 1'b0;
            cfg      <= '0;
            cfg_done <= 1'b0;
`ifdef CFG_FRAME_LOADER_PARITY_EN
            cfg_err  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments here so every flop updates from pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            match_q  <= match_d;
            cfg_done <= commit;
            if (commit) begin
                cfg <= shadow_nxt;
            end
`ifdef CFG_FRAME_LOADER_PARITY_EN
            cfg_err  <= err_d;
`endif
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Self-checking bench for cfg_frame_loader: four instances with different ID/BCAST/lane settings,
// randomized frames checked against a frame-level reference model. Honors CFG_FRAME_LOADER_PARITY_EN.
module tb_cfg_frame_loader;

`ifdef CFG_FRAME_LOADER_PARITY_EN
    localparam int PAR_BEATS = 1;
`else
    localparam int PAR_BEATS = 0;
`endif
    localparam int FULL1 = 3 + 132 + PAR_BEATS;

    logic clk = 1'b0;
    logic rst;
    logic s1;
    logic [0:0] b1;
    logic s4;
    logic [3:0] b4;

    logic os_a, os_b, os_c, os_d;
    logic [0:0] ob_a, ob_b, ob_c;
    logic [3:0] ob_d;
    logic [131:0] cfg_a, cfg_b, cfg_c;
    logic [9:0] cfg_d;
    logic done_a, done_b, done_c, done_d;
    logic busy_a, busy_b, busy_c, busy_d;
`ifdef CFG_FRAME_LOADER_PARITY_EN
    logic err_a, err_b, err_c, err_d;
`endif

    int n_vec = 0;
    int n_err = 0;
    int nd_a, nd_b, nd_c, nd_d;
    logic [131:0] exp_a, exp_b, exp_c;
    logic [9:0] exp_d;

    always #5 clk = ~clk;

    cfg_frame_loader #(.ID_WIDTH(3), .ID(7), .CFG_SIZE(132), .CHAIN_W(1), .BCAST(1'b0)) u_a (
        .clk(clk), .rst(rst), .cfg_in_start(s1), .cfg_bits_in(b1),
        .cfg_out_start(os_a), .cfg_bits_out(ob_a), .cfg(cfg_a), .cfg_done(done_a),
`ifdef CFG_FRAME_LOADER_PARITY_EN
        .cfg_err(err_a),
`endif
        .busy(busy_a));

    cfg_frame_loader #(.ID_WIDTH(3), .ID(2), .CFG_SIZE(132), .CHAIN_W(1), .BCAST(1'b1)) u_b (
        .clk(clk), .rst(rst), .cfg_in_start(s1), .cfg_bits_in(b1),
        .cfg_out_start(os_b), .cfg_bits_out(ob_b), .cfg(cfg_b), .cfg_done(done_b),
`ifdef CFG_FRAME_LOADER_PARITY_EN
        .cfg_err(err_b),
`endif
        .busy(busy_b));

    cfg_frame_loader #(.ID_WIDTH(3), .ID(2), .CFG_SIZE(132), .CHAIN_W(1), .BCAST(1'b0)) u_c (
        .clk(clk), .rst(rst), .cfg_in_start(s1), .cfg_bits_in(b1),
        .cfg_out_start(os_c), .cfg_bits_out(ob_c), .cfg(cfg_c), .cfg_done(done_c),
`ifdef CFG_FRAME_LOADER_PARITY_EN
        .cfg_err(err_c),
`endif
        .busy(busy_c));

    cfg_frame_loader #(.ID_WIDTH(3), .ID(5), .CFG_SIZE(10), .CHAIN_W(4), .BCAST(1'b1)) u_d (
        .clk(clk), .rst(rst), .cfg_in_start(s4), .cfg_bits_in(b4),
        .cfg_out_start(os_d), .cfg_bits_out(ob_d), .cfg(cfg_d), .cfg_done(done_d),
`ifdef CFG_FRAME_LOADER_PARITY_EN
        .cfg_err(err_d),
`endif
        .busy(busy_d));

    task automatic check(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // A frame addresses a tile when its ID matches, or it is all ones and broadcast is enabled.
    function automatic bit hit(input logic [2:0] fid, input int id, input bit bc);
        return (fid == 3'(id)) || (bc && (fid == 3'b111));
    endfunction

    function automatic logic [131:0] rand132();
        return {4'($urandom), $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic beat1(input logic s, input logic b);
        s1 = s;
        b1 = b;
        @(posedge clk);
        #1;
        check("fwd_a", {os_a, ob_a}, {s, b});
        check("fwd_c", {os_c, ob_c}, {s, b});
        nd_a += int'(done_a);
        nd_b += int'(done_b);
        nd_c += int'(done_c);
    endtask

    task automatic beat4(input logic s, input logic [3:0] b);
        s4 = s;
        b4 = b;
        @(posedge clk);
        #1;
        check("fwd_d", {os_d, ob_d}, {s, b});
        nd_d += int'(done_d);
    endtask

    // Sends the start beat plus up to n frame beats on the single-lane bus.
    task automatic send1(input logic [2:0] fid, input logic [131:0] pl, input int n, input bit flip);
        logic q[$];
        for (int i = 0; i < 3; i++) q.push_back(fid[i]);
        for (int i = 0; i < 132; i++) q.push_back(pl[i]);
        if (PAR_BEATS == 1) q.push_back((^pl) ^ flip);
        beat1(1'b1, 1'($urandom));
        check("busy_a_start", busy_a, 1);
        for (int i = 0; i < n && i < q.size(); i++) beat1(1'b0, q[i]);
    endtask

    task automatic frame1(input logic [2:0] fid, input logic [131:0] pl, input bit flip);
        bit ha, hb, hc;
        ha = hit(fid, 7, 1'b0) && !flip;
        hb = hit(fid, 2, 1'b1) && !flip;
        hc = hit(fid, 2, 1'b0) && !flip;
        nd_a = 0; nd_b = 0; nd_c = 0;
        send1(fid, pl, FULL1, flip);
        if (ha) exp_a = pl;
        if (hb) exp_b = pl;
        if (hc) exp_c = pl;
        check("cfg_a", cfg_a, exp_a);
        check("cfg_b", cfg_b, exp_b);
        check("cfg_c", cfg_c, exp_c);
        check("done_a", done_a, ha);
        check("done_b", done_b, hb);
        check("done_c", done_c, hc);
        check("ndone_a", nd_a, ha);
        check("ndone_b", nd_b, hb);
        check("ndone_c", nd_c, hc);
        check("busy_a_end", busy_a, 0);
`ifdef CFG_FRAME_LOADER_PARITY_EN
        check("err_a", err_a, hit(fid, 7, 1'b0) && flip);
        check("err_b", err_b, hit(fid, 2, 1'b1) && flip);
`endif
    endtask

    task automatic frame4(input logic [2:0] fid, input logic [9:0] pl, input bit flip);
        logic [3:0] q[$];
        bit hd;
        hd = hit(fid, 5, 1'b1) && !flip;
        nd_d = 0;
        q.push_back({1'($urandom), fid});
        q.push_back(pl[3:0]);
        q.push_back(pl[7:4]);
        q.push_back({2'($urandom), pl[9:8]});
        if (PAR_BEATS == 1) q.push_back({3'($urandom), (^pl) ^ flip});
        beat4(1'b1, 4'($urandom));
        for (int i = 0; i < q.size(); i++) begin
            beat4(1'b0, q[i]);
            if (i == q.size() - 2) begin
                check("done_d_early", done_d, 0);
                check("busy_d_mid", busy_d, 1);
            end
        end
        if (hd) exp_d = pl;
        check("cfg_d", cfg_d, exp_d);
        check("done_d", done_d, hd);
        check("ndone_d", nd_d, hd);
        check("busy_d_end", busy_d, 0);
`ifdef CFG_FRAME_LOADER_PARITY_EN
        check("err_d", err_d, hit(fid, 5, 1'b1) && flip);
`endif
    endtask

    task automatic idle_check();
        beat1(1'b0, 1'b0);
        check("done_a_1cyc", done_a, 0);
        check("done_b_1cyc", done_b, 0);
        check("hold_a", cfg_a, exp_a);
        check("hold_b", cfg_b, exp_b);
    endtask

    initial begin
        logic [2:0] fid;
        logic [2:0] fid_pick [3];
        fid_pick[0] = 3'b111;
        fid_pick[1] = 3'b010;
        rst = 1'b1; s1 = 1'b0; b1 = '0; s4 = 1'b0; b4 = '0;
        exp_a = '0; exp_b = '0; exp_c = '0; exp_d = '0;
        nd_a = 0; nd_b = 0; nd_c = 0; nd_d = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cfg_a", cfg_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_fwd_a", {os_a, ob_a}, 0);
        check("rst_cfg_d", cfg_d, 0);
        check("rst_fwd_d", {os_d, ob_d}, 0);
        rst = 1'b0;

        // Exact match on a, broadcast on b, miss on c.
        frame1(3'b111, 132'(16'h8000) << 3, 1'b0);
        idle_check();
        // Miss on a, exact match on b and c.
        frame1(3'b010, rand132(), 1'b0);
        idle_check();

        // Randomized frames, some back-to-back with no idle beat.
        for (int k = 0; k < 6; k++) begin
            fid_pick[2] = 3'($urandom);
            fid = fid_pick[$urandom_range(2)];
            frame1(fid, rand132(), 1'b0);
            if (k % 2 == 1) idle_check();
        end

        // Abort mid-LOAD, then a full frame: only the second payload lands.
        nd_a = 0; nd_b = 0;
        send1(3'b111, rand132(), 3 + 40, 1'b0);
        check("abort_ndone_a", nd_a, 0);
        check("abort_cfg_a", cfg_a, exp_a);
        frame1(3'b111, rand132(), 1'b0);
        // Abort during ID.
        send1(3'b010, rand132(), 1, 1'b0);
        frame1(3'b010, rand132(), 1'b0);
        idle_check();

        // Four-lane instance: addressed, broadcast and missed frames.
        frame4(3'd5, 10'h2A5, 1'b0);
        frame4(3'd7, 10'($urandom), 1'b0);
        frame4(3'd3, 10'($urandom), 1'b0);
        frame4(3'd5, 10'($urandom), 1'b0);

`ifdef CFG_FRAME_LOADER_PARITY_EN
        frame1(3'b111, rand132(), 1'b1);
        beat1(1'b0, 1'b0);
        check("err_a_1cyc", err_a, 0);
        frame1(3'b111, rand132(), 1'b0);
        frame4(3'd5, 10'($urandom), 1'b1);
        frame4(3'd5, 10'($urandom), 1'b0);
`endif

        // Reset mid-frame: no partial commit, everything back to zero.
        send1(3'b111, rand132(), 3 + 20, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_a = '0; exp_b = '0; exp_c = '0; exp_d = '0;
        check("mrst_cfg_a", cfg_a, exp_a);
        check("mrst_cfg_b", cfg_b, exp_b);
        check("mrst_busy_a", busy_a, 0);
        check("mrst_done_a", done_a, 0);
        rst = 1'b0;
        frame1(3'b010, rand132(), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cfg_frame_loader.md
# cfg_frame_loader

Parametrised successor to the CLB configuration block: a multi-lane serial configuration loader that receives addressed frames on a daisy-chained config bus, captures the payload when the frame ID matches (or is broadcast), and atomically commits it to the tile's configuration register. Every tile (CLB, switch box, connection box) instantiates one. It sits between the upstream and downstream tiles of the config chain. It forwards all traffic with one cycle of latency and drives the tile's static `cfg` bits.

## Interface
- `ID_WIDTH`, 3: width of the frame ID field.
- `ID`, 7: this tile's ID. The all-ones value is reserved for broadcast.
- `CFG_SIZE`, 132: number of configuration bits held.
- `CHAIN_W`, 1: config bus lanes (bits per beat), 1..8.
- `BCAST`, 1: when 1, an all-ones frame ID matches every tile.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `cfg_in_start`, input, 1: frame-start strobe. It is high on the beat before the first ID beat.
- `cfg_bits_in`, input, CHAIN_W: incoming beat.
- `cfg_out_start`, output, 1: registered copy of `cfg_in_start`.
- `cfg_bits_out`, output, CHAIN_W: registered copy of `cfg_bits_in`.
- `cfg`, output, CFG_SIZE: committed configuration.
- `cfg_done`, output, 1: one-cycle pulse when `cfg` is updated.
- `busy`, output, 1: high while a frame is in progress (state is not IDLE).

## Operation
- Beat counts:
  - ID_BEATS = ceil(ID_WIDTH/CHAIN_W).
  - PL_BEATS = ceil(CFG_SIZE/CHAIN_W).
- Bit order:
  - Fields are sent LSB first.
  - Within a beat, lane k carries field bit (beat*CHAIN_W + k).
  - Pad bits beyond the field width are ignored.
- States: IDLE, ID, LOAD, CHECK (CHECK exists only with the macro).
- IDLE → ID when `cfg_in_start` is sampled high. The beat counter clears.
- ID:
  - Shifts ID_BEATS beats into the ID register.
  - After the last ID beat, the match is evaluated: ID field == `ID`, or (`BCAST` && ID field == all ones).
  - The state then moves to LOAD whether or not the ID matched. The latched `match` flag gates all shadow writes.
- LOAD:
  - Shifts PL_BEATS beats into the shadow register (written only if `match`).
  - After the last beat:
    - If `match`, copy shadow to `cfg` and pulse `cfg_done`.
    - Return to IDLE, or go to CHECK when the macro is defined.
- A non-matching frame is consumed silently: `cfg` is unchanged and no `cfg_done` pulse occurs.
- `cfg_in_start` in any non-IDLE state aborts the current frame. The shadow is discarded, `cfg` is untouched, and the state restarts at ID with the counter cleared.
- Forwarding is unconditional in all states, including matched frames, so downstream tiles see every frame.
- Reset behaviour:
  - `cfg` = 0, `cfg_done` = 0, `busy` = 0, `cfg_out_start` = 0, `cfg_bits_out` = 0.
  - Shadow and ID registers are cleared and the state returns to IDLE.
  - Reset mid-frame drops the frame; no partial commit occurs.

## Timing
- Forward path: exactly 1 cycle from input sample to `cfg_bits_out`/`cfg_out_start`.
- Frame length: 1 start beat + ID_BEATS + PL_BEATS (+1 CHECK beat with the macro).
- Commit timing: `cfg` changes and `cfg_done` is high in the cycle after the last payload (or CHECK) beat is sampled.
  - `cfg_done` is high for exactly 1 cycle.
  - `cfg` holds its value between commits.
- Back-to-back frames: `cfg_in_start` may be asserted on the beat immediately after the last beat of the previous frame. No idle beat is required.
- `busy` rises the cycle after start is sampled. It falls in the same cycle `cfg_done` rises.
- Beat counter width: $clog2(max(ID_BEATS, PL_BEATS)+1).

## Configuration
- Macro: `CFG_FRAME_LOADER_PARITY_EN`.
- Defined:
  - One CHECK beat follows the payload. Lane 0 carries even parity over the CFG_SIZE payload bits; other lanes are ignored.
  - The commit happens only if `match` and the parity is correct.
  - On mismatch, an extra output `cfg_err` (1 bit) pulses for 1 cycle and `cfg` is untouched.
  - `cfg_err` resets to 0.
- Undefined: there is no CHECK state, no `cfg_err` port, and the commit follows LOAD directly.

## Structure
- Shared package `cfg_loader_pkg` holds:
  - The state enum.
  - A `beats(width, lanes)` ceil-divide function.
  - The broadcast-ID constant function (all ones of ID_WIDTH).
- Natural sub-module: `cfg_shadow_sr`, a CHAIN_W-lane shift register of CFG_SIZE bits with write enable and clear, instantiated for the shadow register.
- The forward pipe and FSM stay in the top module.

## Test plan
- **Single-lane match:** CHAIN_W=1, ID=7, frame ID 3'b111 (BCAST=0), payload with 16'h8000 in bits [18:3] → `cfg` equals the payload one cycle after the last beat, and `cfg_done` pulses once.
- **ID miss:** frame ID 3'b010 → `cfg` is unchanged and there is no `cfg_done`. `cfg_bits_out` reproduces the input delayed by 1 cycle for every beat.
- **Broadcast:** BCAST=1, ID=2, frame ID 3'b111 → commit occurs. With BCAST=0 → no commit.
- **Multi-lane:** CHAIN_W=4, CFG_SIZE=10, payload 10'h2A5 → the frame takes 1+1+3 beats, pad lanes are ignored, and `cfg` = 10'h2A5.
- **Abort and reset:** `cfg_in_start` re-asserted mid-LOAD, followed by a full frame → only the second payload is committed. `rst` mid-frame → `cfg` = 0 and `busy` = 0 the next cycle.
- **Parity (macro defined):** correct parity bit → commit. Inverted parity bit → `cfg_err` pulses 1 cycle and `cfg` retains its prior value.
